// File: rtl/inst_fetch_axi_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_axi_pkg
// Shared constants for the instruction-fetch AXI-Lite path: bus widths, reset
// and chip-enable levels, AXI response codes, the fetch FSM state encoding,
// and small decode helpers used by the fetch top level.
// -----------------------------------------------------------------------------
package inst_fetch_axi_pkg;

    localparam int          INST_ADDR_BUS = 32;
    localparam int          INST_BUS      = 32;
    localparam logic [31:0] ZEROWORD      = 32'h0000_0000;
    localparam logic        RST_ENABLE    = 1'b0;
    localparam logic        CHIP_ENABLE   = 1'b1;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_ADDR = 2'd1,
        IF_DATA = 2'd2
    } if_state_e;

    // EXOKAY has no meaning on AXI-Lite, so anything other than OKAY is an error.
    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY:   err = 1'b0;
            AXI_RESP_SLVERR: err = 1'b1;
            AXI_RESP_DECERR: err = 1'b1;
            default:         err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic is_misaligned(input logic [INST_ADDR_BUS-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_axi_rd_master.sv
// -----------------------------------------------------------------------------
// axi_lite_rd_master
// Single-outstanding AXI-Lite read master. A request in IDLE latches the
// address and raises arvalid; after the AR handshake rready is raised until
// the R handshake, which is reported to the core side for one cycle.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   req_i/req_addr_i  core request (only honoured in IDLE)
//   rsp_*_o           R-handshake strobe with data, response and the address
//   ar*/r*            AXI-Lite read address / read data channels
// -----------------------------------------------------------------------------
module axi_lite_rd_master
    import inst_fetch_axi_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [INST_ADDR_BUS-1:0] req_addr_i,
    output logic                     rsp_valid_o,
    output logic [INST_BUS-1:0]      rsp_data_o,
    output logic [1:0]               rsp_resp_o,
    output logic [INST_ADDR_BUS-1:0] rsp_addr_o,
    output logic [INST_ADDR_BUS-1:0] araddr_o,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    input  logic [INST_BUS-1:0]      rdata_i,
    input  logic [1:0]               rresp_i,
    input  logic                     rvalid_i,
    output logic                     rready_o
);

    if_state_e                state_q, state_d;
    logic [INST_ADDR_BUS-1:0] araddr_q, araddr_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= IF_IDLE;
            araddr_q  <= ZEROWORD;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (state_q)
            IF_IDLE: begin
                if (req_i) begin
                    araddr_d  = req_addr_i;
                    arvalid_d = 1'b1;
                    state_d   = IF_ADDR;
                end
            end
            IF_ADDR: begin
                if (arvalid_q && arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = IF_DATA;
                end
            end
            IF_DATA: begin
                if (rvalid_i && rready_q) begin
                    rready_d = 1'b0;
                    state_d  = IF_IDLE;
                end
            end
            default: begin
                state_d   = IF_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // araddr_q stays valid through DATA, so it tags the returned word even if
    // the PC has moved on in the meantime.
    assign rsp_valid_o = (state_q == IF_DATA) && rvalid_i && rready_q;
    assign rsp_data_o  = rdata_i;
    assign rsp_resp_o  = rresp_i;
    assign rsp_addr_o  = araddr_q;
    assign araddr_o    = araddr_q;
    assign arvalid_o   = arvalid_q;
    assign rready_o    = rready_q;

endmodule

// File: rtl/inst_fetch_axi.sv
// -----------------------------------------------------------------------------
// inst_fetch_axi
// Instruction-fetch responder with a one-entry fetch buffer. A miss on an
// aligned pc (with ce) starts one AXI-Lite read; the returned word is tagged
// with the read address. stall_req is held until the buffer hits the pc.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   ce, pc             fetch enable and address from the PC stage
//   inst, inst_valid   buffered word and hit indication towards IF/ID
//   stall_req          miss stall to the pipeline controller
//   fetch_err          one-cycle pulse: misaligned pc or non-OKAY rresp
//   ar*, r*            AXI-Lite read channels
// -----------------------------------------------------------------------------
module inst_fetch_axi
    import inst_fetch_axi_pkg::*;
#(
    parameter logic [31:0] RESET_TAG  = 32'h0000_0000,
    parameter logic [2:0]  ARPROT_VAL = 3'b100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic [INST_ADDR_BUS-1:0] pc,
    output logic [INST_BUS-1:0]      inst,
    output logic                     inst_valid,
    output logic                     stall_req,
    output logic                     fetch_err,
    output logic [INST_ADDR_BUS-1:0] araddr,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [INST_BUS-1:0]      rdata,
    input  logic [1:0]               rresp,
    input  logic                     rvalid,
    output logic                     rready
);

    logic [INST_ADDR_BUS-1:0] tag_q, tag_d;
    logic                     tag_v_q, tag_v_d;
    logic [INST_BUS-1:0]      buf_q, buf_d;
    logic                     fetch_err_q, fetch_err_d;
    logic [INST_ADDR_BUS-1:0] mis_addr_q, mis_addr_d;
    logic                     mis_seen_q, mis_seen_d;

    logic                     ce_on, hit, misaligned, mis_new, req;
    logic                     rsp_valid;
    logic [INST_BUS-1:0]      rsp_data;
    logic [1:0]               rsp_resp;
    logic [INST_ADDR_BUS-1:0] rsp_addr;

    assign ce_on      = (ce == CHIP_ENABLE);
    assign hit        = tag_v_q && (tag_q == pc);
    assign misaligned = is_misaligned(pc);
    assign req        = ce_on && !hit && !misaligned;

    // A misaligned pc held for many cycles reports once; a different
    // misaligned address reports again.
    assign mis_new = ce_on && misaligned && !(mis_seen_q && (mis_addr_q == pc));

    assign inst       = buf_q;
    assign inst_valid = ce_on && hit && !misaligned;
    assign stall_req  = req;
    assign fetch_err  = fetch_err_q;
    assign arprot     = ARPROT_VAL;

    axi_lite_rd_master u_rd_master (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .req_addr_i (pc),
        .rsp_valid_o(rsp_valid),
        .rsp_data_o (rsp_data),
        .rsp_resp_o (rsp_resp),
        .rsp_addr_o (rsp_addr),
        .araddr_o   (araddr),
        .arvalid_o  (arvalid),
        .arready_i  (arready),
        .rdata_i    (rdata),
        .rresp_i    (rresp),
        .rvalid_i   (rvalid),
        .rready_o   (rready)
    );

    always_comb begin
        tag_d       = tag_q;
        tag_v_d     = tag_v_q;
        buf_d       = buf_q;
        mis_addr_d  = mis_addr_q;
        mis_seen_d  = mis_seen_q;
        fetch_err_d = (rsp_valid && resp_is_error(rsp_resp)) || mis_new;
        if (rsp_valid) begin
            // A failed read still fills the buffer (with a NOP) so the
            // pipeline advances instead of refetching forever.
            buf_d   = resp_is_error(rsp_resp) ? ZEROWORD : rsp_data;
            tag_d   = rsp_addr;
            tag_v_d = 1'b1;
        end
        if (mis_new) begin
            mis_seen_d = 1'b1;
            mis_addr_d = pc;
        end else if (ce_on && !misaligned) begin
            mis_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            tag_q       <= RESET_TAG;
            tag_v_q     <= 1'b0;
            buf_q       <= ZEROWORD;
            fetch_err_q <= 1'b0;
            mis_addr_q  <= ZEROWORD;
            mis_seen_q  <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            tag_v_q     <= tag_v_d;
            buf_q       <= buf_d;
            fetch_err_q <= fetch_err_d;
            mis_addr_q  <= mis_addr_d;
            mis_seen_q  <= mis_seen_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_axi
// Directed bench for inst_fetch_axi with a small AXI-Lite slave whose address
// and data wait states and response code are set per test.
// -----------------------------------------------------------------------------
module tb_inst_fetch_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b0;
    logic [31:0] pc  = 32'h0;
    logic [31:0] inst;
    logic        inst_valid, stall_req, fetch_err;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata   = 32'h0;
    logic [1:0]  rresp   = 2'b00;
    logic        rvalid  = 1'b0;
    logic        rready;

    int          checks = 0;
    int          errors = 0;

    int          ar_delay = 0;
    int          r_delay  = 0;
    logic [1:0]  sl_resp  = 2'b00;
    logic [31:0] pend_addr = 32'h0;
    int          ar_cnt = 0;
    int          r_cnt  = 0;

    inst_fetch_axi #(
        .RESET_TAG (32'h0000_0000),
        .ARPROT_VAL(3'b100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .pc        (pc),
        .inst      (inst),
        .inst_valid(inst_valid),
        .stall_req (stall_req),
        .fetch_err (fetch_err),
        .araddr    (araddr),
        .arprot    (arprot),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2402_0001;
            32'h0000_0004: return 32'h8C22_0004;
            32'h0000_000C: return 32'h1111_000C;
            32'h0000_0100: return 32'h2222_0100;
            default:       return {16'hDEAD, a[15:0]};
        endcase
    endfunction

    // Slave updates on the falling edge so the DUT sees stable inputs at
    // every rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                arready = 1'b0;
                rvalid  = 1'b0;
                ar_cnt  = 0;
                r_cnt   = 0;
            end else begin
                if (arvalid) begin
                    if (ar_cnt == ar_delay) begin
                        arready   = 1'b1;
                        pend_addr = araddr;
                        ar_cnt    = 0;
                    end else begin
                        arready = 1'b0;
                        ar_cnt++;
                    end
                end else begin
                    arready = 1'b0;
                    ar_cnt  = 0;
                end
                if (rready) begin
                    if (r_cnt == r_delay) begin
                        rvalid = 1'b1;
                        rresp  = sl_resp;
                        rdata  = (sl_resp == 2'b00) ? mem_word(pend_addr) : 32'hBAD0_BAD0;
                        r_cnt  = 0;
                    end else begin
                        rvalid = 1'b0;
                        r_cnt++;
                    end
                end else begin
                    rvalid = 1'b0;
                    r_cnt  = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives pc in the current cycle (cycle 0) and follows the miss until
    // stall_req drops, checking the AR address and the stall length.
    task automatic run_fetch(input logic [31:0] a, input int ard, input int rd,
                             input logic [1:0] resp, input int exp_stall,
                             input logic [31:0] exp_inst);
        int n;
        int arv;
        ar_delay = ard;
        r_delay  = rd;
        sl_resp  = resp;
        pc       = a;
        #1;
        n   = 0;
        arv = 0;
        while (stall_req === 1'b1 && n < 40) begin
            if (arvalid) begin
                arv++;
                chk("araddr", araddr, a);
            end
            chk("fetch_err_idle", {31'b0, fetch_err}, 32'd0);
            n++;
            cyc();
        end
        chk("stall_cycles", n, exp_stall);
        chk("ar_cycles", arv, ard + 1);
        chk("inst", inst, exp_inst);
        chk("inst_valid", {31'b0, inst_valid}, 32'd1);
        $display("fetch pc=%h inst=%h stall_cycles=%0d resp=%b", a, inst, n, resp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, ce high while reset is held.
        rst = 1'b0; ce = 1'b0; pc = 32'h0;
        cyc(); cyc();
        ce = 1'b1;
        #1;
        chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
        chk("rst_rready", {31'b0, rready}, 32'd0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_stall_req", {31'b0, stall_req}, 32'd1);
        chk("arprot", {29'b0, arprot}, 32'd4);
        cyc();
        rst = 1'b1;

        // Zero-wait miss at 0x0.
        run_fetch(32'h0, 0, 0, 2'b00, 3, 32'h2402_0001);

        // Held pc hits; no further AR.
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_arvalid", {31'b0, arvalid}, 32'd0);
            chk("hold_stall", {31'b0, stall_req}, 32'd0);
            chk("hold_inst_valid", {31'b0, inst_valid}, 32'd1);
        end
        $display("hold pc=%h inst=%h five hit cycles", pc, inst);

        // ce low: no valid, no stall, buffer holds.
        ce = 1'b0;
        #1;
        chk("ce0_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("ce0_stall", {31'b0, stall_req}, 32'd0);
        chk("ce0_inst", inst, 32'h2402_0001);
        cyc();
        ce = 1'b1;

        // Wait states: 2 on AR, 3 on R -> 8 stall cycles.
        run_fetch(32'h4, 2, 3, 2'b00, 8, 32'h8C22_0004);

        // SLVERR on 0x8 -> NOP word and a single fetch_err pulse.
        run_fetch(32'h8, 0, 0, 2'b10, 3, 32'h0);
        chk("err_pulse", {31'b0, fetch_err}, 32'd1);
        cyc();
        chk("err_pulse_end", {31'b0, fetch_err}, 32'd0);

        // pc moves from 0xC to 0x100 while the 0xC read is in DATA.
        ar_delay = 0; r_delay = 2; sl_resp = 2'b00;
        pc = 32'hC;
        #1;
        chk("sw_stall_c0", {31'b0, stall_req}, 32'd1);
        cyc();
        chk("sw_arvalid_c1", {31'b0, arvalid}, 32'd1);
        chk("sw_araddr_c1", araddr, 32'hC);
        cyc();
        chk("sw_rready_c2", {31'b0, rready}, 32'd1);
        pc = 32'h100;
        cyc(); cyc();
        chk("sw_rready_c4", {31'b0, rready}, 32'd1);
        cyc();
        chk("sw_idle_arvalid", {31'b0, arvalid}, 32'd0);
        chk("sw_buf_c", inst, 32'h1111_000C);
        chk("sw_tag", dut.tag_q, 32'hC);
        chk("sw_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("sw_stall", {31'b0, stall_req}, 32'd1);
        cyc();
        chk("sw_arvalid2", {31'b0, arvalid}, 32'd1);
        chk("sw_araddr2", araddr, 32'h100);
        for (int i = 0; i < 20 && stall_req === 1'b1; i++) cyc();
        chk("sw_final_inst", inst, 32'h2222_0100);
        chk("sw_final_valid", {31'b0, inst_valid}, 32'd1);
        $display("switch pc=%h inst=%h refetched after 0xC", pc, inst);

        // Reset while in ADDR (slave withholds arready).
        ar_delay = 5; r_delay = 0;
        pc = 32'h200;
        #1;
        cyc();
        chk("ra_arvalid_before", {31'b0, arvalid}, 32'd1);
        rst = 1'b0;
        cyc();
        chk("ra_arvalid", {31'b0, arvalid}, 32'd0);
        chk("ra_rready", {31'b0, rready}, 32'd0);
        chk("ra_araddr", araddr, 32'h0);
        chk("ra_inst", inst, 32'h0);
        chk("ra_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("ra_fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("ra_stall", {31'b0, stall_req}, 32'd1);
        $display("reset during ADDR pc=%h arvalid=%b", pc, arvalid);

        // Misaligned pc: no AR, no stall, one error pulse per distinct address.
        rst = 1'b1;
        ar_delay = 0;
        pc = 32'h6;
        #1;
        chk("mis_stall", {31'b0, stall_req}, 32'd0);
        chk("mis_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mis_err_c0", {31'b0, fetch_err}, 32'd0);
        cyc();
        chk("mis_err_pulse", {31'b0, fetch_err}, 32'd1);
        chk("mis_arvalid", {31'b0, arvalid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mis_err_once", {31'b0, fetch_err}, 32'd0);
            chk("mis_no_ar", {31'b0, arvalid}, 32'd0);
            chk("mis_no_stall", {31'b0, stall_req}, 32'd0);
        end
        pc = 32'hA;
        #1;
        cyc();
        chk("mis2_err_pulse", {31'b0, fetch_err}, 32'd1);
        $display("misaligned pc=%h one pulse per address", pc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_axi.md
# inst_fetch_axi

Instruction-fetch responder sitting between the program counter and the AXI-Lite interconnect. It accepts the fetch address and chip enable driven by the PC stage, issues a single-beat AXI-Lite read for each new address, and returns the instruction word to IF/ID. It holds a one-entry fetch buffer and raises a stall request to the pipeline controller until the word for the current PC is available.

## Interface
Parameters:
- `RESET_TAG`, 32'h0000_0000: tag value loaded at reset; the tag-valid bit is cleared regardless.
- `ARPROT_VAL`, 3'b100: constant driven on `arprot` (instruction, secure, unprivileged).

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  reset; synchronous, active-low (`rst==0` resets on the next edge).
- `ce`  in  1  fetch enable from the PC stage.
- `pc`  in  32  fetch address from the PC stage.
- `inst`  out  32  instruction word for `pc`.
- `inst_valid`  out  1  `inst` corresponds to the current `pc`.
- `stall_req`  out  1  to the pipeline controller; drives `stall[0]` upstream.
- `fetch_err`  out  1  one-cycle pulse on a misaligned `pc` or a non-OKAY `rresp`.
- `araddr`  out  32;  `arprot`  out  3;  `arvalid`  out  1;  `arready`  in  1.
- `rdata`  in  32;  `rresp`  in  2;  `rvalid`  in  1;  `rready`  out  1.

## Operation
- **State:**
  - FSM states: IDLE, ADDR, DATA.
  - Buffer registers: `tag[31:0]`, `tag_v`, `buf[31:0]`.
- **Hit rule:** `hit = tag_v && tag==pc`.
  - `inst = buf`.
  - `inst_valid = ce && hit`.
  - `stall_req = ce && !hit && !misaligned`.
- **IDLE:** when `ce && !hit && pc[1:0]==2'b00`:
  - Latch `araddr<=pc`, set `arvalid<=1`, go to ADDR.
  - Otherwise stay in IDLE.
- **ADDR:** hold `arvalid` and `araddr` stable until `arready`.
  - On `arvalid&&arready`: clear `arvalid`, set `rready<=1`, go to DATA.
- **DATA:** on `rvalid&&rready`:
  - Set `buf<=rdata`, `tag<=araddr`, `tag_v<=1`.
  - Clear `rready`, return to IDLE.
- **Read error** (`rresp!=2'b00`):
  - `buf<=32'h0000_0000` (NOP). Tag is still written so the pipeline advances.
  - `fetch_err` pulses in the cycle after the R handshake.
- **Misaligned `pc`** (`pc[1:0]!=0` with `ce=1`):
  - No AR is issued; `stall_req=0`, `inst_valid=0`.
  - `fetch_err` pulses once per distinct misaligned address.
- **`pc` changes while a transaction is in flight:**
  - The transaction completes; AXI-Lite reads are not aborted.
  - The tag is taken from `araddr`, not `pc`.
  - The next IDLE compares against the new `pc` and refetches.
- **`ce=0`:**
  - No new AR is issued; an in-flight transaction completes.
  - `inst_valid=0`, `stall_req=0`, `buf` holds.
- **At most one outstanding read**, ever.

## Timing
- **Reset values** (`rst==0` at an edge):
  - State IDLE.
  - `arvalid=0`, `rready=0`, `araddr=0`.
  - `tag=RESET_TAG`, `tag_v=0`, `buf=0`.
  - `fetch_err=0`.
  - `inst=0`, `inst_valid=0`.
  - `stall_req` follows its combinational rule (1 if `ce=1`, because `tag_v=0`).
- **Reset mid-transaction:** drops `arvalid`/`rready` immediately. This is permitted because the interconnect shares `rst`.
- **Miss latency**, with `pc` new in cycle 0 and zero-wait slave (`arready` and `rvalid` asserted the first cycle they are sampled):
  - `arvalid` high in cycle 1, handshake in cycle 1.
  - `rready` high in cycle 2, R handshake in cycle 2.
  - `inst_valid=1` in cycle 3.
  - `stall_req` is high for cycles 0–2: 3 stall cycles minimum.
- **Slave wait states:** each `arready` or `rvalid` wait cycle adds one cycle of latency.
- **Hit latency:** 0; `inst_valid` is combinational on `pc`.
- **`arready` already high before `arvalid`:** the handshake completes in the first cycle `arvalid` is high.
- **`rvalid` already high on entry to DATA:** the handshake completes in the first DATA cycle.
- **Output registers:** `arvalid`, `araddr` and `rready` are registered; no combinational path runs from AXI inputs to AXI outputs.

## Structure
- **Shared include files:**
  - Existing global/ROM includes: `INST_ADDR_BUS`, `INST_BUS`, `ZEROWORD`, `RST_ENABLE` (1'b0), `CHIP_ENABLE`.
  - New in a shared AXI include: `AXI_RESP_OKAY`/`SLVERR`/`DECERR`, and the FSM state encodings `IF_IDLE`, `IF_ADDR`, `IF_DATA`.
- **Sub-module:** one sub-module, `axi_lite_rd_master` (ADDR/DATA handshake FSM, with request/response on the core side). The top level keeps the tag/buffer, hit logic and error pulse.

## Test plan
- Reset, then `ce=1`, `pc=0x0`, zero-wait slave returning `0x2402_0001`:
  - `stall_req` is high for 3 cycles.
  - `inst=0x2402_0001`, `inst_valid=1` in cycle 3.
  - `araddr=0x0` during AR.
- Same `pc` held for 5 cycles after the fill: no further `arvalid`; `stall_req=0` throughout.
- Slave with 2-cycle `arready` delay and 3-cycle `rvalid` delay, `pc=0x4`:
  - `arvalid` and `araddr=0x4` stay stable while waiting.
  - `stall_req` is high for 8 cycles in total.
- `rresp=2'b10` on a fetch of `0x8`:
  - `inst=0`, `inst_valid=1`.
  - `fetch_err` is high for exactly 1 cycle.
- `pc` switched from `0xC` to `0x100` during DATA:
  - `tag` is written with `0xC`.
  - A second AR to `0x100` starts in the cycle after returning to IDLE.
  - Final `inst` is the word at `0x100`.
- `rst` pulled low during ADDR, and separately with `pc=0x6`:
  - Reset case: `arvalid=0` the next cycle; all outputs at their reset values.
  - Misaligned case: no AR is issued, `fetch_err` pulses once, `stall_req=0`.
